// File: rtl/mblt_pkg.sv
// mblt_pkg: shared types, widths and the yellow-pixel classifier for the line tracker.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
package mblt_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIVIDE  = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int CX_W  = 16;
  localparam int CNT_W = 16;
  localparam int SUM_W = 32;

  // Colour thresholds on the 4-bit channels of RGB444.
  localparam logic [3:0] Y_R_MIN = 4'd8;
  localparam logic [3:0] Y_G_MIN = 4'd8;
  localparam logic [3:0] Y_B_MAX = 4'd5;

  // Per-band accumulator: yellow pixel count and sum of their x positions.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum;
  } band_acc_t;

  function automatic logic is_yellow(input logic [11:0] rgb444);
    return (rgb444[11:8] >= Y_R_MIN) &&
           (rgb444[7:4]  >= Y_G_MIN) &&
           (rgb444[3:0]  <= Y_B_MAX);
  endfunction

endpackage

// File: rtl/mblt_serial_div.sv
// mblt_serial_div: 32/16 restoring divider producing a 16-bit quotient.
// Latency: done pulses 17 cycles after start (1 load + 16 iterations).
// Backpressure: none; start always (re)loads, abort drops an in-flight divide.
//
// Ports: pclk/reset_n (sync active-low), start/abort controls, dividend/divisor
// operands sampled on start, busy while iterating, done one-cycle pulse,
// quotient valid from done until the next start. Divisor 0 yields quotient 0;
// a quotient that would not fit in 16 bits saturates to all ones.
module mblt_serial_div
  import mblt_pkg::*;
(
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [CX_W-1:0]  quotient
);

  localparam int ITER   = SUM_W - CNT_W;
  localparam int ITER_W = $clog2(ITER);

  logic [CNT_W-1:0]  rem;
  logic [ITER-1:0]   dlo;
  logic [CX_W-1:0]   quo;
  logic [CNT_W-1:0]  div_r;
  logic [ITER_W-1:0] iter;
  logic              div_zero;
  logic              div_ovf;

  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    rem_diff;
  logic              q_bit;
  logic [CNT_W-1:0]  rem_nxt;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits.
  always_comb begin
    rem_sh   = {rem, dlo[ITER-1]};
    rem_diff = rem_sh - {1'b0, div_r};
    q_bit    = (rem_sh >= {1'b0, div_r});
    rem_nxt  = q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      rem      <= '0;
      dlo      <= '0;
      quo      <= '0;
      div_r    <= '0;
      iter     <= '0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= dividend[SUM_W-1:ITER];
        dlo      <= dividend[ITER-1:0];
        div_r    <= divisor;
        quo      <= '0;
        iter     <= '0;
        div_zero <= (divisor == '0);
        // High half >= divisor means the quotient cannot fit in ITER bits.
        div_ovf  <= (dividend[SUM_W-1:ITER] >= divisor);
        busy     <= 1'b1;
      end else if (abort) begin
        busy <= 1'b0;
      end else if (busy) begin
        rem  <= rem_nxt;
        dlo  <= {dlo[ITER-2:0], 1'b0};
        quo  <= {quo[CX_W-2:0], q_bit};
        iter <= iter + ITER_W'(1);
        if (iter == ITER_W'(ITER - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = div_zero ? '0 : (div_ovf ? '1 : quo);

endmodule

// File: rtl/multi_band_line_tracker.sv
// multi_band_line_tracker: per-band yellow-line centroid, slope and lost flag from OV7670 video.
// Latency: frame_pulse N_BANDS*17+1 pclk cycles after the vsync rise that ends a frame.
// Backpressure: none; video is never stalled, a vsync during DIVIDE aborts and restarts.
//
// Ports: pclk, reset_n (sync active-low); video in: vsync, href, we, pix_rgb444.
// Results out (updated atomically with frame_pulse): band_cx, band_count, band_valid,
// slope, slope_valid, lost. overrun_cnt counts aborted divides (saturating).
// Build option: define MBLT_IIR_EN to low-pass each valid band centroid by SMOOTH_SHIFT.
module multi_band_line_tracker
  import mblt_pkg::*;
#(
  parameter int N_BANDS      = 4,
  parameter int BAND_LINES   = 20,
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int MIN_PIXELS   = 8,
  parameter int LOST_FRAMES  = 3,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                     pclk,
  input  logic                     reset_n,
  input  logic                     vsync,
  input  logic                     href,
  input  logic                     we,
  input  logic [11:0]              pix_rgb444,
  output logic                     frame_pulse,
  output logic [CX_W*N_BANDS-1:0]  band_cx,
  output logic [CNT_W*N_BANDS-1:0] band_count,
  output logic [N_BANDS-1:0]       band_valid,
  output logic signed [CX_W:0]     slope,
  output logic                     slope_valid,
  output logic                     lost,
  output logic [7:0]               overrun_cnt
);

  localparam int               BW        = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam logic [BW-1:0]    LAST_BAND = BW'(N_BANDS - 1);
  localparam logic [CX_W-1:0]  X_LIM     = CX_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_PIXELS);
  localparam logic [7:0]       LOST_MAX  = 8'(LOST_FRAMES);

  // Elaboration-time parameter sanity.
  if (N_BANDS < 1 || N_BANDS * BAND_LINES > IMG_HEIGHT) begin : g_bad_bands
    $error("bands do not fit in the frame");
  end
  if (IMG_WIDTH < 1 || IMG_WIDTH >= (1 << CX_W)) begin : g_bad_width
    $error("IMG_WIDTH out of range");
  end
  if (SMOOTH_SHIFT < 0 || SMOOTH_SHIFT > CX_W) begin : g_bad_shift
    $error("SMOOTH_SHIFT out of range");
  end
  if (LOST_FRAMES < 1 || LOST_FRAMES > 255 || MIN_PIXELS < 0) begin : g_bad_thresh
    $error("threshold parameter out of range");
  end

  // ---------------- video front end ----------------
  logic vsync_q, href_q;
  logic vsync_rise, href_rise, href_fall;
  logic [CX_W-1:0] x_cnt, x_cur;
  logic [15:0]     line_cnt;
  logic            pix_yellow;
  logic [N_BANDS-1:0] in_band;
  band_acc_t       live_acc [N_BANDS];

  assign vsync_rise = vsync & ~vsync_q;
  assign href_rise  = href & ~href_q;
  assign href_fall  = ~href & href_q;

  // A pixel arriving with the href rise is x=0, before the register clears.
  assign x_cur      = href_rise ? '0 : x_cnt;
  assign pix_yellow = we & href & (x_cur < X_LIM) & is_yellow(pix_rgb444);

  // Band k spans the BAND_LINES lines ending IMG_HEIGHT-1-k*BAND_LINES.
  always_comb begin
    int lo;
    in_band = '0;
    lo      = 0;
    for (int k = 0; k < N_BANDS; k++) begin
      lo         = IMG_HEIGHT - (k + 1) * BAND_LINES;
      in_band[k] = (int'(line_cnt) >= lo) && (int'(line_cnt) < lo + BAND_LINES);
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      x_cnt    <= '0;
      line_cnt <= '0;
      for (int k = 0; k < N_BANDS; k++) live_acc[k] <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;

      if (we && href && (x_cur < X_LIM)) x_cnt <= x_cur + CX_W'(1);
      else                               x_cnt <= x_cur;

      if (vsync_rise)                          line_cnt <= '0;
      else if (href_fall && line_cnt != '1)    line_cnt <= line_cnt + 16'd1;

      // The vsync rise hands the totals to the shadows, so clear wins here.
      for (int k = 0; k < N_BANDS; k++) begin
        if (vsync_rise) begin
          live_acc[k] <= '0;
        end else if (pix_yellow && in_band[k]) begin
          live_acc[k].cnt <= live_acc[k].cnt + CNT_W'(1);
          live_acc[k].sum <= live_acc[k].sum + SUM_W'(x_cur);
        end
      end
    end
  end

  // ---------------- divide / publish ----------------
  state_t          state;
  logic [BW-1:0]   band, band_nxt;
  band_acc_t       shadow_acc [N_BANDS];
  logic [CX_W-1:0] q_reg      [N_BANDS];
  logic [CX_W-1:0] cx_r       [N_BANDS];
  logic [CNT_W-1:0] cnt_r     [N_BANDS];
  logic [7:0]      lost_cnt;

  logic             div_start, div_abort, div_busy, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [CX_W-1:0]  div_quo;

  // Band 0 starts straight from the live totals in the vsync-rise cycle (the
  // same values landing in the shadows), which keeps each band at 17 cycles.
  always_comb begin
    band_nxt     = (band == LAST_BAND) ? band : band + BW'(1);
    div_abort    = vsync_rise && (state == DIVIDE);
    div_start    = 1'b0;
    div_dividend = shadow_acc[band_nxt].sum;
    div_divisor  = shadow_acc[band_nxt].cnt;
    if (vsync_rise) begin
      div_start    = 1'b1;
      div_dividend = live_acc[0].sum;
      div_divisor  = live_acc[0].cnt;
    end else if (state == DIVIDE && div_done && !div_busy && band != LAST_BAND) begin
      div_start = 1'b1;
    end
  end

  mblt_serial_div u_div (
    .pclk     (pclk),
    .reset_n  (reset_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Next-published values; the last band's quotient is taken straight off the divider.
  logic [CX_W-1:0]      q_sel   [N_BANDS];
  logic [CX_W-1:0]      new_cx  [N_BANDS];
  logic [N_BANDS-1:0]   new_valid;
  logic signed [CX_W:0] new_slope;
  logic [7:0]           new_lost_cnt;
`ifdef MBLT_IIR_EN
  logic signed [CX_W:0] iir_diff [N_BANDS];
  logic signed [CX_W:0] iir_sum  [N_BANDS];
`endif

  always_comb begin
    for (int k = 0; k < N_BANDS; k++) begin
`ifdef MBLT_IIR_EN
      iir_diff[k] = '0;
      iir_sum[k]  = '0;
`endif
      q_sel[k]     = (k == N_BANDS - 1) ? div_quo : q_reg[k];
      new_valid[k] = (shadow_acc[k].cnt >= MIN_CNT);
      new_cx[k]    = cx_r[k];
      if (new_valid[k]) begin
`ifdef MBLT_IIR_EN
        if (band_valid[k]) begin
          iir_diff[k] = $signed({1'b0, q_sel[k]}) - $signed({1'b0, cx_r[k]});
          iir_sum[k]  = $signed({1'b0, cx_r[k]}) + (iir_diff[k] >>> SMOOTH_SHIFT);
          new_cx[k]   = iir_sum[k][CX_W-1:0];
        end else begin
          new_cx[k] = q_sel[k];
        end
`else
        new_cx[k] = q_sel[k];
`endif
      end
    end
    new_slope = $signed({1'b0, new_cx[N_BANDS-1]}) - $signed({1'b0, new_cx[0]});
    if (new_valid == '0) new_lost_cnt = (lost_cnt >= LOST_MAX) ? LOST_MAX : lost_cnt + 8'd1;
    else                 new_lost_cnt = '0;
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state       <= ACCUM;
      band        <= '0;
      lost_cnt    <= '0;
      frame_pulse <= 1'b0;
      band_valid  <= '0;
      slope       <= '0;
      slope_valid <= 1'b0;
      lost        <= 1'b0;
      overrun_cnt <= '0;
      for (int k = 0; k < N_BANDS; k++) begin
        shadow_acc[k] <= '0;
        q_reg[k]      <= '0;
        cx_r[k]       <= '0;
        cnt_r[k]      <= '0;
      end
    end else begin
      frame_pulse <= 1'b0;
      if (vsync_rise) begin
        // Any vsync rise snapshots and restarts; mid-divide it is an overrun.
        for (int k = 0; k < N_BANDS; k++) shadow_acc[k] <= live_acc[k];
        state <= DIVIDE;
        band  <= '0;
        if (state == DIVIDE && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end else begin
        case (state)
          ACCUM: state <= ACCUM;
          DIVIDE: begin
            if (div_done && !div_busy) begin
              q_reg[band] <= div_quo;
              if (band == LAST_BAND) begin
                for (int k = 0; k < N_BANDS; k++) begin
                  cx_r[k]  <= new_cx[k];
                  cnt_r[k] <= shadow_acc[k].cnt;
                end
                band_valid  <= new_valid;
                slope       <= new_slope;
                slope_valid <= new_valid[0] & new_valid[N_BANDS-1];
                lost_cnt    <= new_lost_cnt;
                lost        <= (new_lost_cnt == LOST_MAX);
                frame_pulse <= 1'b1;
                state       <= PUBLISH;
              end else begin
                band <= band + BW'(1);
              end
            end
          end
          PUBLISH: state <= ACCUM;
          default: state <= ACCUM;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_BANDS; k++) begin : g_pack
    assign band_cx[k*CX_W +: CX_W]     = cx_r[k];
    assign band_count[k*CNT_W +: CNT_W] = cnt_r[k];
  end

endmodule

// File: tb/tb_multi_band_line_tracker.sv
`timescale 1ns/1ps
module tb_multi_band_line_tracker;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        we = 1'b0;
  logic [11:0] pix_rgb444 = '0;
  logic        frame_pulse;
  logic [31:0] band_cx;
  logic [31:0] band_count;
  logic [1:0]  band_valid;
  logic signed [16:0] slope;
  logic        slope_valid;
  logic        lost;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int npulse;
  logic [15:0] line_mask [8];

  always #5 pclk = ~pclk;

  multi_band_line_tracker #(
    .N_BANDS(2), .BAND_LINES(2), .IMG_WIDTH(16), .IMG_HEIGHT(8),
    .MIN_PIXELS(2), .LOST_FRAMES(3), .SMOOTH_SHIFT(2)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .we(we),
    .pix_rgb444(pix_rgb444), .frame_pulse(frame_pulse), .band_cx(band_cx),
    .band_count(band_count), .band_valid(band_valid), .slope(slope),
    .slope_valid(slope_valid), .lost(lost), .overrun_cnt(overrun_cnt)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // lines 0-3 get lo, band 1 (lines 4,5) gets b1, band 0 (lines 6,7) gets b0
  task automatic fill_mask(input logic [15:0] lo, input logic [15:0] b1, input logic [15:0] b0);
    for (int l = 0; l < 4; l++) line_mask[l] = lo;
    line_mask[4] = b1; line_mask[5] = b1;
    line_mask[6] = b0; line_mask[7] = b0;
  endtask

  // 18 pixels per line: x=16,17 are yellow but lie past the line width.
  task automatic send_line(input logic [15:0] m);
    @(negedge pclk);
    href = 1'b1;
    for (int x = 0; x < 18; x++) begin
      we = 1'b1;
      if (x >= 16)      pix_rgb444 = 12'h885;
      else if (m[x])    pix_rgb444 = 12'h885;
      else if (x[0])    pix_rgb444 = 12'hFF6;
      else              pix_rgb444 = 12'h785;
      @(negedge pclk);
    end
    we = 1'b0; href = 1'b0; pix_rgb444 = '0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic send_frame();
    for (int l = 0; l < 8; l++) send_line(line_mask[l]);
  endtask

  // Raise vsync at the current negedge; optional second rise at rerise_at.
  task automatic vsync_frame(input int rerise_at);
    lat = -1; npulse = 0;
    vsync = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge pclk);
      if (frame_pulse) begin
        npulse++;
        if (lat < 0) lat = k;
      end
      if (k == 4) vsync = 1'b0;
      if (rerise_at > 0 && k == rerise_at) vsync = 1'b1;
      if (rerise_at > 0 && k == rerise_at + 4) vsync = 1'b0;
    end
  endtask

  task automatic check_out(input string tag, input int c0, input int c1, input int x0,
                           input int x1, input int v, input int s, input int sv, input int l);
    check({tag, ".cnt0"}, band_count[15:0], c0);
    check({tag, ".cnt1"}, band_count[31:16], c1);
    check({tag, ".cx0"}, band_cx[15:0], x0);
    check({tag, ".cx1"}, band_cx[31:16], x1);
    check({tag, ".valid"}, band_valid, v);
    check({tag, ".slope"}, slope, s);
    check({tag, ".slope_valid"}, slope_valid, sv);
    check({tag, ".lost"}, lost, l);
  endtask

  initial begin
    // 1: reset with random video
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      href = 1'($urandom); we = 1'($urandom); pix_rgb444 = 12'($urandom);
      vsync = (i < 2) ? 1'($urandom) : 1'b0;
    end
    @(negedge pclk);
    check("rst.pulse", frame_pulse, 0);
    check_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst.overrun", overrun_cnt, 0);
    href = 1'b0; we = 1'b0; pix_rgb444 = '0; vsync = 1'b0;
    reset_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (frame_pulse) npulse++;
    end
    check("idle.pulses", npulse, 0);

    // 2: x=5,6 on every line
    fill_mask(16'h0060, 16'h0060, 16'h0060);
    send_frame(); vsync_frame(0);
    check("f1.latency", lat, 35);
    check("f1.pulses", npulse, 1);
    check_out("f1", 4, 4, 5, 5, 3, 0, 1, 0);

    // 3: band 0 at x=10, band 1 at x=4
    fill_mask(16'h0000, 16'h0010, 16'h0400);
    send_frame(); vsync_frame(0);
    check_out("f2", 2, 2, 10, 4, 3, -6, 1, 0);

    // 4: a single yellow pixel in band 0
    fill_mask(16'h0000, 16'h0000, 16'h0000);
    line_mask[7] = 16'h0008;
    send_frame(); vsync_frame(0);
    check_out("f3", 1, 0, 10, 4, 0, -6, 0, 0);

    // valid frame clears the lost counter before the empty run
    fill_mask(16'h0060, 16'h0060, 16'h0060);
    send_frame(); vsync_frame(0);
    check_out("f4", 4, 4, 5, 5, 3, 0, 1, 0);

    // 5: three empty frames, then a good one
    fill_mask(16'h0000, 16'h0000, 16'h0000);
    for (int f = 0; f < 3; f++) begin
      send_frame(); vsync_frame(0);
      check($sformatf("empty%0d.pulses", f), npulse, 1);
      check($sformatf("empty%0d.lost", f), lost, (f == 2) ? 1 : 0);
    end
    check_out("empty", 0, 0, 5, 5, 0, 0, 0, 1);
    fill_mask(16'h0060, 16'h0060, 16'h0060);
    send_frame(); vsync_frame(0);
    check_out("recover", 4, 4, 5, 5, 3, 0, 1, 0);

    // 6a: vsync re-rise 10 cycles into the divide
    fill_mask(16'h0000, 16'h0010, 16'h0400);
    send_frame(); vsync_frame(10);
    check("ovr.overrun", overrun_cnt, 1);
    check("ovr.pulses", npulse, 1);
    check("ovr.latency", lat, 45);
    check_out("ovr", 0, 0, 5, 5, 0, 0, 0, 0);

    // 6b: reset in the middle of a divide
    fill_mask(16'h0060, 16'h0060, 16'h0060);
    send_frame();
    vsync = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (k == 4) vsync = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge pclk);
    reset_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (frame_pulse) npulse++;
    end
    check("rstdiv.pulses", npulse, 0);
    check("rstdiv.overrun", overrun_cnt, 0);
    check_out("rstdiv", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
